// File: rtl/disp_seq_pkg.sv
// Shared encodings for the axis display path.
//   SEL_X/SEL_Y/SEL_Z/SEL_T : 2-bit data-select codes seen by the display mux
//   state_t                 : sequencer states, encoded so the state equals its select code
//   axis_words_t            : one coherent set of displayed words
// Optional feature macro: AXIS_SEQ_TEMP_EN (adds the temperature word and state S_T).
package disp_seq_pkg;

  localparam logic [1:0] SEL_X = 2'b00;
  localparam logic [1:0] SEL_Y = 2'b01;
  localparam logic [1:0] SEL_Z = 2'b10;
  localparam logic [1:0] SEL_T = 2'b11;

  typedef enum logic [1:0] {
    S_X = SEL_X,
    S_Y = SEL_Y,
    S_Z = SEL_Z,
    S_T = SEL_T
  } state_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
`ifdef AXIS_SEQ_TEMP_EN
    logic [15:0] t;
`endif
  } axis_words_t;

  function automatic state_t next_state(input state_t s);
    case (s)
      S_X:     return S_Y;
      S_Y:     return S_Z;
`ifdef AXIS_SEQ_TEMP_EN
      S_Z:     return S_T;
`else
      S_Z:     return S_X;
`endif
      default: return S_X;
    endcase
  endfunction

  function automatic logic [1:0] sel_of(input state_t s);
    case (s)
      S_X:     return SEL_X;
      S_Y:     return SEL_Y;
      S_Z:     return SEL_Z;
      default: return SEL_T;
    endcase
  endfunction

endpackage

// File: rtl/axis_display_sequencer_if.sv
// Gyro sample bus feeding the display sequencer.
//   x_in/y_in/z_in : raw axis words
//   temp_in        : raw temperature word (only with AXIS_SEQ_TEMP_EN)
//   data_valid     : 1-cycle strobe, words valid this cycle
// master = gyro interface side (drives), slave = sequencer side (samples).
interface axis_display_sequencer_if;
  logic [15:0] x_in;
  logic [15:0] y_in;
  logic [15:0] z_in;
  logic        data_valid;
`ifdef AXIS_SEQ_TEMP_EN
  logic [15:0] temp_in;

  modport master (output x_in, y_in, z_in, temp_in, data_valid);
  modport slave  (input  x_in, y_in, z_in, temp_in, data_valid);
`else
  modport master (output x_in, y_in, z_in, data_valid);
  modport slave  (input  x_in, y_in, z_in, data_valid);
`endif
endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, level debouncer and rising-edge
// detector.
//   clk, rst (sync, active-low) ; btn_raw : asynchronous button, active-high
//   btn_evt : registered 1-cycle pulse when the debounced level rises
// The new level is accepted after DB_CYCLES consecutive samples that differ
// from the current stable level; any agreeing sample restarts the count.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_evt
);

  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          evt_q, evt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    evt_d = stable_d & ~stable_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      evt_q    <= 1'b0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      evt_q    <= evt_d;
    end
  end

  assign btn_evt = evt_q;

endmodule

// File: rtl/axis_display_sequencer.sv
// Axis display sequencer: steps the display select X->Y->Z->X (->T with
// AXIS_SEQ_TEMP_EN) on a dwell timer or on a debounced button, and publishes
// rate-limited, coherent snapshots of the gyro words.
//   clk, rst (sync, active-low)
//   btn_next  : raw push-button        mode_auto : 1 = dwell stepping
//   hold      : freeze displayed words (select still steps)
//   gyro      : sample bus (slave modport)
//   sel       : display select        x/y/z_axis : displayed words
//   temp_data : displayed temperature (only with AXIS_SEQ_TEMP_EN)
//   step_pulse: 1-cycle pulse, high in the first cycle sel shows its new value
module axis_display_sequencer
  import disp_seq_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 200_000_000,
  parameter int unsigned DB_CYCLES    = 2_000_000,
  parameter int unsigned UPD_CYCLES   = 25_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     btn_next,
  input  logic                     mode_auto,
  input  logic                     hold,
  axis_display_sequencer_if.slave  gyro,
  output logic [1:0]               sel,
  output logic [15:0]              x_axis,
  output logic [15:0]              y_axis,
  output logic [15:0]              z_axis,
`ifdef AXIS_SEQ_TEMP_EN
  output logic [15:0]              temp_data,
`endif
  output logic                     step_pulse
);

  localparam int unsigned DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned UPD_W   = (UPD_CYCLES > 1) ? $clog2(UPD_CYCLES) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [UPD_W-1:0]   UPD_LAST   = UPD_W'(UPD_CYCLES - 1);

  logic btn_evt;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_btn_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_next),
    .btn_evt(btn_evt)
  );

  state_t             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic               step_pulse_q, step_pulse_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [UPD_W-1:0]   upd_q, upd_d;
  logic               pending_q, pending_d;
  axis_words_t        shadow_q, shadow_d;
  axis_words_t        disp_q, disp_d;
  logic               adv;
  logic               upd_tick;

  always_comb begin
    // In auto mode the button is ignored, so a coincident btn_evt cannot
    // produce a second advance.
    adv = mode_auto ? (dwell_q == DWELL_LAST) : btn_evt;

    state_d = state_q;
    if (adv) begin
      state_d = next_state(state_q);
    end
    sel_d        = sel_of(state_d);
    step_pulse_d = adv;

    // Held at 0 in manual mode so entering auto mode starts a full dwell.
    dwell_d = (!mode_auto || adv) ? '0 : dwell_q + 1'b1;

    upd_tick = (upd_q == UPD_LAST);
    upd_d    = upd_tick ? '0 : upd_q + 1'b1;

    disp_d    = disp_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (upd_tick && pending_q && !hold) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
    end
    // A sample arriving on the copy cycle lands in the shadow after the copy
    // took the old one, and keeps pending set for the next tick.
    if (gyro.data_valid) begin
      shadow_d.x = gyro.x_in;
      shadow_d.y = gyro.y_in;
      shadow_d.z = gyro.z_in;
`ifdef AXIS_SEQ_TEMP_EN
      shadow_d.t = gyro.temp_in;
`endif
      pending_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_X;
      sel_q        <= SEL_X;
      step_pulse_q <= 1'b0;
      dwell_q      <= '0;
      upd_q        <= '0;
      pending_q    <= 1'b0;
      shadow_q     <= '0;
      disp_q       <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      step_pulse_q <= step_pulse_d;
      dwell_q      <= dwell_d;
      upd_q        <= upd_d;
      pending_q    <= pending_d;
      shadow_q     <= shadow_d;
      disp_q       <= disp_d;
    end
  end

  assign sel        = sel_q;
  assign step_pulse = step_pulse_q;
  assign x_axis     = disp_q.x;
  assign y_axis     = disp_q.y;
  assign z_axis     = disp_q.z;
`ifdef AXIS_SEQ_TEMP_EN
  assign temp_data  = disp_q.t;
`endif

endmodule

// File: tb/tb_axis_display_sequencer.sv
// Self-checking bench for axis_display_sequencer (DWELL=10, DB=4, UPD=8).
// Published words are checked against a scoreboard queue filled when samples
// are driven; select stepping is checked at fixed cycle offsets.
module tb_axis_display_sequencer;

  localparam int unsigned DW  = 10;
  localparam int unsigned DB  = 4;
  localparam int unsigned UPD = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_next = 1'b0;
  logic        mode_auto = 1'b1;
  logic        hold = 1'b0;
  logic [1:0]  sel;
  logic [15:0] x_axis, y_axis, z_axis;
  logic        step_pulse;
`ifdef AXIS_SEQ_TEMP_EN
  logic [15:0] temp_data;
`endif

  axis_display_sequencer_if gyro ();

  axis_display_sequencer #(
    .DWELL_CYCLES(DW),
    .DB_CYCLES   (DB),
    .UPD_CYCLES  (UPD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_next  (btn_next),
    .mode_auto (mode_auto),
    .hold      (hold),
    .gyro      (gyro.slave),
    .sel       (sel),
    .x_axis    (x_axis),
    .y_axis    (y_axis),
    .z_axis    (z_axis),
`ifdef AXIS_SEQ_TEMP_EN
    .temp_data (temp_data),
`endif
    .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic [15:0] t;
  } exp_t;

  typedef struct {
    logic [15:0] x_in;
    logic [15:0] y_in;
    logic [15:0] z_in;
    logic [15:0] t_in;
    exp_t        exp_out;
  } vec_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          fails = 0;
  int          pub_cnt = 0;
  int          step_cnt = 0;
  int unsigned cyc = 0;
  logic [15:0] lx = '0, ly = '0, lz = '0, lt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] cur_temp();
`ifdef AXIS_SEQ_TEMP_EN
    return temp_data;
`else
    return 16'h0000;
`endif
  endfunction

  // Watches every cycle: counts steps, pops the scoreboard on each publish.
  task automatic monitor();
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (step_pulse === 1'b1) step_cnt++;
      if (x_axis !== lx || y_axis !== ly || z_axis !== lz || cur_temp() !== lt) begin
        if (rst === 1'b1) begin
          pub_cnt++;
          if (sb_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_publish: got x=%h y=%h z=%h expected no change", x_axis, y_axis, z_axis);
          end else begin
            e = sb_q.pop_front();
            chk("pub_x_axis", 32'(x_axis), 32'(e.x));
            chk("pub_y_axis", 32'(y_axis), 32'(e.y));
            chk("pub_z_axis", 32'(z_axis), 32'(e.z));
`ifdef AXIS_SEQ_TEMP_EN
            chk("pub_temp_data", 32'(temp_data), 32'(e.t));
`endif
          end
        end
        lx = x_axis;
        ly = y_axis;
        lz = z_axis;
        lt = cur_temp();
      end
    end
  endtask

  task automatic do_reset(input logic auto_m);
    @(negedge clk);
    rst = 1'b0;
    mode_auto = auto_m;
    btn_next = 1'b0;
    hold = 1'b0;
    gyro.data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sel", 32'(sel), 32'h0);
    chk("reset_x_axis", 32'(x_axis), 32'h0);
    chk("reset_y_axis", 32'(y_axis), 32'h0);
    chk("reset_z_axis", 32'(z_axis), 32'h0);
    chk("reset_step_pulse", 32'(step_pulse), 32'h0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drive_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                              input logic [15:0] t, input logic push);
    exp_t e;
    @(negedge clk);
    gyro.x_in = x;
    gyro.y_in = y;
    gyro.z_in = z;
`ifdef AXIS_SEQ_TEMP_EN
    gyro.temp_in = t;
`endif
    gyro.data_valid = 1'b1;
    if (push) begin
      e.x = x; e.y = y; e.z = z; e.t = t;
      sb_q.push_back(e);
    end
    @(negedge clk);
    gyro.data_valid = 1'b0;
  endtask

  task automatic wait_pub(input string name, input int budget);
    int start;
    int n;
    start = pub_cnt;
    n = 0;
    while (pub_cnt == start && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (pub_cnt == start) begin
      fails++;
      $display("FAIL %s: got no publish within %0d cycles, expected one", name, budget);
    end
  endtask

  // Returns #2 after the edge that leaves cyc == target.
  task automatic wait_cyc(input int unsigned target);
    while (cyc < target) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input int hold_cycles);
    @(negedge clk);
    btn_next = 1'b1;
    repeat (hold_cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[4];
    logic [1:0]  sel_seq[3];
    int          sc0;
    int unsigned c0;

    gyro.x_in = '0;
    gyro.y_in = '0;
    gyro.z_in = '0;
    gyro.data_valid = 1'b0;
`ifdef AXIS_SEQ_TEMP_EN
    gyro.temp_in = '0;
`endif

    vecs[0] = '{16'h1234, 16'h0001, 16'h0002, 16'h0011, '{16'h1234, 16'h0001, 16'h0002, 16'h0011}};
    vecs[1] = '{16'hA5A5, 16'h5A5A, 16'hFFFF, 16'h0022, '{16'hA5A5, 16'h5A5A, 16'hFFFF, 16'h0022}};
    vecs[2] = '{16'h8000, 16'h7FFF, 16'h0100, 16'h0033, '{16'h8000, 16'h7FFF, 16'h0100, 16'h0033}};
    vecs[3] = '{16'h0FF0, 16'hF00F, 16'h1234, 16'h0044, '{16'h0FF0, 16'hF00F, 16'h1234, 16'h0044}};
    sel_seq[0] = 2'b10;
    sel_seq[1] = 2'b00;
    sel_seq[2] = 2'b01;

    fork
      monitor();
    join_none

    // Auto mode: first step exactly 10 cycles after reset release.
    do_reset(1'b1);
    repeat (9) @(posedge clk);
    #1;
    chk("auto_sel_before_dwell", 32'(sel), 32'h0);
    @(posedge clk);
    #1;
    chk("auto_sel_after_dwell", 32'(sel), 32'h1);
    chk("auto_step_pulse", 32'(step_pulse), 32'h1);

    // Manual mode: glitch rejected, held press steps on the 7th edge.
    do_reset(1'b0);
    sc0 = step_cnt;
    press(2);
    @(negedge clk);
    btn_next = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("glitch_sel", 32'(sel), 32'h0);
    chk("glitch_steps", 32'(step_cnt - sc0), 32'h0);
    press(6);
    chk("press_sel_edge6", 32'(sel), 32'h0);
    @(posedge clk);
    #1;
    chk("press_sel_edge7", 32'(sel), 32'h1);
    chk("press_step_pulse", 32'(step_pulse), 32'h1);
    @(posedge clk);
    #1;
    chk("press_step_pulse_end", 32'(step_pulse), 32'h0);
    @(negedge clk);
    btn_next = 1'b0;
    repeat (10) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      press(10);
      chk("press_wrap_sel", 32'(sel), 32'(sel_seq[i]));
      @(negedge clk);
      btn_next = 1'b0;
      repeat (10) @(posedge clk);
    end
    #1;
    chk("manual_step_count", 32'(step_cnt - sc0), 32'h4);

    // Table-driven snapshots: each sample published at the next update tick.
    for (int i = 0; i < 4; i++) begin
      drive_sample(vecs[i].x_in, vecs[i].y_in, vecs[i].z_in, vecs[i].t_in, 1'b0);
      sb_q.push_back(vecs[i].exp_out);
      wait_pub("table_publish", 2 * UPD + 2);
    end

    // Hold: BEEF stays hidden until hold drops, then appears within one tick.
    @(negedge clk);
    hold = 1'b1;
    drive_sample(16'hBEEF, 16'h0BEE, 16'h00BE, 16'h0055, 1'b0);
    sc0 = pub_cnt;
    repeat (3 * UPD) @(posedge clk);
    #1;
    chk("hold_x_frozen", 32'(x_axis), 32'h0FF0);
    chk("hold_no_publish", 32'(pub_cnt - sc0), 32'h0);
    sb_q.push_back('{16'hBEEF, 16'h0BEE, 16'h00BE, 16'h0055});
    @(negedge clk);
    hold = 1'b0;
    wait_pub("hold_release_publish", UPD + 1);

    // Sample on the copy cycle: old shadow now, new sample one tick later.
    c0 = cyc;
    wait_cyc(c0 + 1);
    drive_sample(16'h1111, 16'h2222, 16'h3333, 16'h0066, 1'b1);
    wait_cyc(c0 + UPD - 1);
    drive_sample(16'h4444, 16'h5555, 16'h6666, 16'h0077, 1'b1);
    wait_cyc(c0 + UPD);
    chk("coincide_old_shadow", 32'(x_axis), 32'h1111);
    wait_cyc(c0 + 2 * UPD - 1);
    chk("coincide_still_old", 32'(x_axis), 32'h1111);
    wait_cyc(c0 + 2 * UPD);
    chk("coincide_new_sample", 32'(x_axis), 32'h4444);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);

    // Auto mode with btn_evt landing on dwell expiry: one advance only.
    do_reset(1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    btn_next = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("coinc_sel_before", 32'(sel), 32'h0);
    @(posedge clk);
    #1;
    chk("coinc_sel_once", 32'(sel), 32'h1);
    repeat (9) @(posedge clk);
    #1;
    chk("coinc_sel_hold", 32'(sel), 32'h1);
    @(posedge clk);
    #1;
    chk("coinc_sel_next_dwell", 32'(sel), 32'h2);
    @(negedge clk);
    btn_next = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_dwell_reset_sel", 32'(sel), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    chk("restart_sel_before", 32'(sel), 32'h0);
    @(posedge clk);
    #1;
    chk("restart_sel_after", 32'(sel), 32'h1);

`ifdef AXIS_SEQ_TEMP_EN
    begin
      logic [1:0] tseq[4];
      tseq[0] = 2'b01;
      tseq[1] = 2'b10;
      tseq[2] = 2'b11;
      tseq[3] = 2'b00;
      do_reset(1'b1);
      for (int i = 0; i < 4; i++) begin
        repeat (DW) @(posedge clk);
        #1;
        chk("temp_sel_cycle", 32'(sel), 32'(tseq[i]));
      end
      drive_sample(16'h5555, 16'h6666, 16'h7777, 16'h0042, 1'b1);
      wait_pub("temp_publish", 2 * UPD + 2);
      chk("temp_data_value", 32'(temp_data), 32'h0042);
    end
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
